// File: rtl/fsm_pattern_checker_pkg.sv
// Shared definitions for the pattern checker: phase and checker-state
// encodings plus helpers describing the generator's 1,0,1 sequence.
package fsm_pattern_checker_pkg;

  // Phase encodings match the pattern generator so that the values are
  // directly comparable across the link.
  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_STATE1 = 2'd1,
    PH_STATE2 = 2'd2,
    PH_STATE3 = 2'd3
  } phase_t;

  // Checker alignment state.
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_t;

  // Width of the inline run / miss counters.
  localparam int CNT_W = 4;

  // Bit the generator emits in a given phase (IDLE has no defined bit).
  function automatic logic expected_bit(input phase_t ph);
    logic bit_v;
    case (ph)
      PH_STATE1: bit_v = 1'b1;
      PH_STATE2: bit_v = 1'b0;
      PH_STATE3: bit_v = 1'b1;
      default:   bit_v = 1'b0;
    endcase
    return bit_v;
  endfunction

  // Phase that follows the given one after a valid bit.
  function automatic phase_t next_phase(input phase_t ph);
    phase_t nxt_v;
    case (ph)
      PH_STATE1: nxt_v = PH_STATE2;
      PH_STATE2: nxt_v = PH_STATE3;
      PH_STATE3: nxt_v = PH_STATE1;
      default:   nxt_v = PH_IDLE;
    endcase
    return nxt_v;
  endfunction

endpackage

// File: rtl/fsm_pattern_checker_sat_counter.sv
// Saturating up-counter with synchronous clear. A clear that coincides
// with an increment yields 1 so the coincident event is not lost.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_C = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_C = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;

  // Next count: clear has priority, increment stops at the maximum value.
  always_comb begin
    count_nxt_s = count_r;
    if (clr) begin
      if (inc) begin
        count_nxt_s = ONE_C;
      end else begin
        count_nxt_s = {WIDTH{1'b0}};
      end
    end else if (inc && (count_r != MAX_C)) begin
      count_nxt_s = count_r + ONE_C;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= {WIDTH{1'b0}};
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/fsm_pattern_checker.sv
// Receive-side checker for the 3-phase 1,0,1 pattern generator. Hunts for
// the single 0 in the sequence to align, confirms alignment over a run of
// matching bits, then monitors the stream and counts bit errors while
// locked, dropping lock after a run of consecutive mismatches.
module fsm_pattern_checker
  import fsm_pattern_checker_pkg::*;
#(
  parameter int LOCK_CNT   = 6,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             err_clr,
  output logic             locked,
  output logic [1:0]       phase,
  output logic             match_pulse,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] LOCK_LIM_C   = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] UNLOCK_LIM_C = CNT_W'(UNLOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO_C   = {CNT_W{1'b0}};

  chk_state_t       state_r;
  chk_state_t       state_nxt_s;
  phase_t           phase_r;
  phase_t           phase_nxt_s;
  logic [CNT_W-1:0] run_r;
  logic [CNT_W-1:0] run_nxt_s;
  logic [CNT_W-1:0] miss_r;
  logic [CNT_W-1:0] miss_nxt_s;
  logic             locked_r;
  logic             match_pulse_r;
  logic             err_pulse_r;
  logic             match_nxt_s;
  logic             err_nxt_s;
  logic             bit_ok_s;

  assign bit_ok_s = (in_bit == expected_bit(phase_r));

  // State register: FSM state, phase, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= ST_HUNT;
      phase_r       <= PH_IDLE;
      run_r         <= CNT_ZERO_C;
      miss_r        <= CNT_ZERO_C;
      locked_r      <= 1'b0;
      match_pulse_r <= 1'b0;
      err_pulse_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      phase_r       <= phase_nxt_s;
      run_r         <= run_nxt_s;
      miss_r        <= miss_nxt_s;
      locked_r      <= (state_nxt_s == ST_LOCKED);
      match_pulse_r <= match_nxt_s;
      err_pulse_r   <= err_nxt_s;
    end
  end

  // Next-state logic: alignment search, lock qualification and lock loss.
  always_comb begin
    state_nxt_s = state_r;
    phase_nxt_s = phase_r;
    run_nxt_s   = run_r;
    miss_nxt_s  = miss_r;
    if (in_valid) begin
      case (state_r)
        ST_HUNT: begin
          if (!in_bit) begin
            // The only 0 in the pattern is state2, so the next bit is state3.
            state_nxt_s = ST_SYNC;
            phase_nxt_s = PH_STATE3;
            run_nxt_s   = CNT_ZERO_C;
            miss_nxt_s  = CNT_ZERO_C;
          end else begin
            state_nxt_s = ST_HUNT;
            phase_nxt_s = PH_IDLE;
          end
        end
        ST_SYNC: begin
          if (bit_ok_s) begin
            phase_nxt_s = next_phase(phase_r);
            if ((run_r + CNT_ONE_C) == LOCK_LIM_C) begin
              state_nxt_s = ST_LOCKED;
              run_nxt_s   = CNT_ZERO_C;
              miss_nxt_s  = CNT_ZERO_C;
            end else begin
              run_nxt_s = run_r + CNT_ONE_C;
            end
          end else begin
            // A mismatching 0 is not reused for alignment; hunting restarts.
            state_nxt_s = ST_HUNT;
            phase_nxt_s = PH_IDLE;
            run_nxt_s   = CNT_ZERO_C;
          end
        end
        ST_LOCKED: begin
          if (bit_ok_s) begin
            phase_nxt_s = next_phase(phase_r);
            miss_nxt_s  = CNT_ZERO_C;
          end else if ((miss_r + CNT_ONE_C) == UNLOCK_LIM_C) begin
            state_nxt_s = ST_HUNT;
            phase_nxt_s = PH_IDLE;
            miss_nxt_s  = CNT_ZERO_C;
          end else begin
            phase_nxt_s = next_phase(phase_r);
            miss_nxt_s  = miss_r + CNT_ONE_C;
          end
        end
        default: begin
          state_nxt_s = ST_HUNT;
          phase_nxt_s = PH_IDLE;
          run_nxt_s   = CNT_ZERO_C;
          miss_nxt_s  = CNT_ZERO_C;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      phase_nxt_s = phase_r;
    end
  end

  // Output logic: per-bit match / error events for the pulse registers.
  always_comb begin
    match_nxt_s = 1'b0;
    err_nxt_s   = 1'b0;
    if (in_valid) begin
      case (state_r)
        ST_SYNC: begin
          match_nxt_s = bit_ok_s;
          err_nxt_s   = 1'b0;
        end
        ST_LOCKED: begin
          match_nxt_s = bit_ok_s;
          err_nxt_s   = !bit_ok_s;
        end
        default: begin
          match_nxt_s = 1'b0;
          err_nxt_s   = 1'b0;
        end
      endcase
    end else begin
      match_nxt_s = 1'b0;
      err_nxt_s   = 1'b0;
    end
  end

  sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (err_clr),
    .inc   (err_nxt_s),
    .count (err_count)
  );

  assign locked      = locked_r;
  assign phase       = phase_r;
  assign match_pulse = match_pulse_r;
  assign err_pulse   = err_pulse_r;

endmodule

// File: tb/tb_fsm_pattern_checker.sv
// Directed self-checking bench for fsm_pattern_checker. Two instances share
// the stimulus: the default configuration and one with a 2-bit err_count
// to exercise saturation.
module tb_fsm_pattern_checker;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_bit;
  logic       err_clr;

  logic       locked;
  logic [1:0] phase;
  logic       match_pulse;
  logic       err_pulse;
  logic [7:0] err_count;

  logic       locked_2;
  logic [1:0] phase_2;
  logic       match_pulse_2;
  logic       err_pulse_2;
  logic [1:0] err_count_2;

  int checks = 0;
  int errors = 0;

  fsm_pattern_checker #(.LOCK_CNT(6), .UNLOCK_CNT(3), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .err_clr(err_clr), .locked(locked), .phase(phase),
    .match_pulse(match_pulse), .err_pulse(err_pulse), .err_count(err_count)
  );

  fsm_pattern_checker #(.LOCK_CNT(6), .UNLOCK_CNT(3), .ERR_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .err_clr(err_clr), .locked(locked_2), .phase(phase_2),
    .match_pulse(match_pulse_2), .err_pulse(err_pulse_2),
    .err_count(err_count_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and return just after the sampling edge.
  task automatic step(input logic v, input logic b, input logic c);
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
    err_clr  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic lk, input int ph,
                           input logic mp, input logic ep, input int ec,
                           input int ec2);
    check_eq({tag, ".locked"}, 32'(locked), 32'(lk));
    check_eq({tag, ".phase"}, 32'(phase), 32'(ph));
    check_eq({tag, ".match"}, 32'(match_pulse), 32'(mp));
    check_eq({tag, ".err"}, 32'(err_pulse), 32'(ep));
    check_eq({tag, ".errcnt"}, 32'(err_count), 32'(ec));
    check_eq({tag, ".locked_w2"}, 32'(locked_2), 32'(lk));
    check_eq({tag, ".errcnt_w2"}, 32'(err_count_2), 32'(ec2));
  endtask

  logic s1_bits [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  int   s1_ph   [9] = '{0, 0, 3, 1, 2, 3, 1, 2, 3};
  logic s1_mp   [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  logic rs_bits [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  int   rs_ph   [6] = '{1, 2, 3, 1, 2, 3};

  logic al_bits [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  int   al_ph   [10] = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 1};
  int   al_ec   [10] = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
  int   al_ec2  [10] = '{1, 1, 2, 2, 3, 3, 3, 3, 3, 3};

  initial begin
    int mcount;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    err_clr  = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      check_all($sformatf("rst%0d", i), 1'b0, 0, 1'b0, 1'b0, 0, 0);
    end

    // Align and lock on 1,1,0,1,1,0,1,1,0.
    reset  = 1'b1;
    mcount = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, s1_bits[i], 1'b0);
      if (match_pulse) mcount++;
      check_all($sformatf("lock%0d", i), (i == 8), s1_ph[i], s1_mp[i], 1'b0, 0, 0);
    end
    check_eq("lock.match_total", 32'(mcount), 32'd6);

    // Single flipped bit while locked, then recovery.
    step(1'b1, 1'b1, 1'b0); check_all("t3_pre", 1'b1, 1, 1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0); check_all("t3_err", 1'b1, 2, 1'b0, 1'b1, 1, 1);
    step(1'b1, 1'b0, 1'b0); check_all("t3_ok1", 1'b1, 3, 1'b1, 1'b0, 1, 1);
    step(1'b1, 1'b1, 1'b0); check_all("t3_ok2", 1'b1, 1, 1'b1, 1'b0, 1, 1);
    step(1'b1, 1'b1, 1'b0); check_all("t3_ok3", 1'b1, 2, 1'b1, 1'b0, 1, 1);

    // Clear on an idle cycle, then three consecutive errors drop lock.
    step(1'b0, 1'b1, 1'b1); check_all("t4_clr", 1'b1, 2, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b0); check_all("t4_e1", 1'b1, 3, 1'b0, 1'b1, 1, 1);
    step(1'b1, 1'b0, 1'b0); check_all("t4_e2", 1'b1, 1, 1'b0, 1'b1, 2, 2);
    step(1'b1, 1'b0, 1'b0); check_all("t4_e3", 1'b0, 0, 1'b0, 1'b1, 3, 3);

    // SYNC aborted by a mismatch after 4 matches.
    step(1'b0, 1'b0, 1'b1); check_all("t5_clr", 1'b0, 0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0); check_all("t5_sync", 1'b0, 3, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, rs_bits[i], 1'b0);
      check_all($sformatf("t5_m%0d", i), 1'b0, rs_ph[i], 1'b1, 1'b0, 0, 0);
    end
    step(1'b1, 1'b0, 1'b0); check_all("t5_miss", 1'b0, 0, 1'b0, 1'b0, 0, 0);

    // Resync needs a fresh 0 followed by 6 matches.
    step(1'b1, 1'b0, 1'b0); check_all("t5_rs0", 1'b0, 3, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, rs_bits[i], 1'b0);
      check_all($sformatf("t5_rs%0d", i + 1), (i == 5), rs_ph[i], 1'b1, 1'b0, 0, 0);
    end

    // Alternating error/correct: 2-bit counter saturates at 3.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, al_bits[i], 1'b0);
      check_all($sformatf("t6_alt%0d", i), 1'b1, al_ph[i], (i % 2 == 1),
                (i % 2 == 0), al_ec[i], al_ec2[i]);
    end
    step(1'b1, 1'b0, 1'b1); check_all("t6_clr_err", 1'b1, 2, 1'b0, 1'b1, 1, 1);

    // Gaps in in_valid while locked.
    step(1'b1, 1'b0, 1'b0); check_all("t7_v1", 1'b1, 3, 1'b1, 1'b0, 1, 1);
    step(1'b0, 1'b0, 1'b0); check_all("t7_i1", 1'b1, 3, 1'b0, 1'b0, 1, 1);
    step(1'b0, 1'b0, 1'b0); check_all("t7_i2", 1'b1, 3, 1'b0, 1'b0, 1, 1);
    step(1'b1, 1'b1, 1'b0); check_all("t7_v2", 1'b1, 1, 1'b1, 1'b0, 1, 1);

    // Reset mid-lock with a mismatching valid bit present.
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0); check_all("t8_rst", 1'b0, 0, 1'b0, 1'b0, 0, 0);
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0); check_all("t8_post", 1'b0, 0, 1'b0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
